tft_pattern_timing_gen: RTL

Parametrised successor to the fixed 800x480 TFT timing/test-pattern generator. Produces HD/VD/DENA panel timing for any resolution and porch set, with selectable sync polarity, and drives pixel-aligned RGB888 test patterns: solid colour cycling, colour bars and checkerboard, plus an optional gradient. It sits between the pixel clock domain and the TFT panel connector and is the bring-up source for new panels.

---
 rtl/tft_pattern_timing_gen.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/tft_pattern_timing_gen.sv
// Parametrised TFT panel timing (HD/VD/DENA) and RGB888 test-pattern generator.
// Define TFT_GRADIENT_PATTERN_EN to build the mode-3 gradient; otherwise mode 3 repeats mode 0.
module tft_pattern_timing_gen #(
    parameter int   HPIXELS          = 800,
    parameter int   HFP              = 20,
    parameter int   HSW              = 140,
    parameter int   HBP              = 140,
    parameter int   VLINES           = 480,
    parameter int   VFP              = 3,
    parameter int   VSW              = 10,
    parameter int   VBP              = 7,
    parameter logic HSYNC_POL        = 1'b0,
    parameter logic VSYNC_POL        = 1'b0,
    parameter int   FRAMES_PER_COLOR = 60,
    parameter int   CHECK_LOG2       = 5
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [1:0]  Mode,
    output logic        DENA,
    output logic        HD,
    output logic        VD,
    output logic        SC,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        FrameStart,
    output logic [10:0] PixelX,
    output logic [10:0] PixelY
);

    localparam int HTOTAL = HSW + HBP + HPIXELS + HFP;
    localparam int VTOTAL = VSW + VBP + VLINES + VFP;

    localparam logic [10:0] H_LAST = 11'(HTOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(VTOTAL - 1);
    localparam logic [10:0] H_SYNC = 11'(HSW);
    localparam logic [10:0] V_SYNC = 11'(VSW);
    localparam logic [10:0] H_ACT0 = 11'(HSW + HBP);
    localparam logic [10:0] H_ACT1 = 11'(HSW + HBP + HPIXELS - 1);
    localparam logic [10:0] V_ACT0 = 11'(VSW + VBP);
    localparam logic [10:0] V_ACT1 = 11'(VSW + VBP + VLINES - 1);

    localparam int BAR_W = HPIXELS / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    localparam int FW = (FRAMES_PER_COLOR > 1) ? $clog2(FRAMES_PER_COLOR) : 1;
    localparam logic [FW-1:0] FRM_LAST = FW'(FRAMES_PER_COLOR - 1);

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_e;

    function automatic logic [23:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0: return 24'hFFFFFF;
            3'd1: return 24'hFF0000;
            3'd2: return 24'h00FF00;
            3'd3: return 24'h0000FF;
            3'd4: return 24'h000000;
            3'd5: return 24'h00FFFF;
            3'd6: return 24'hFF00FF;
            3'd7: return 24'hFFFF00;
        endcase
    endfunction

    // Counter state
    logic [10:0]   h_q, h_d, v_q, v_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [2:0]    colour_q, colour_d;
    mode_e         mode_q, mode_d;
    logic [2:0]    bar_q, bar_d;
    logic [BW-1:0] sub_q, sub_d;

    // Registered outputs
    logic          dena_q, dena_d, hd_q, hd_d, vd_q, vd_d, fs_q, fs_d;
    logic [23:0]   rgb_q, rgb_d;
    logic [10:0]   pxo_q, pxo_d, pyo_q, pyo_d;

    logic          active, frame_end;
    logic [10:0]   px, py;
    logic [23:0]   rgb;

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        h_d      = h_q;
        v_d      = v_q;
        frame_d  = frame_q;
        colour_d = colour_q;
        mode_d   = mode_q;
        bar_d    = bar_q;
        sub_d    = sub_q;
        rgb      = 24'h000000;

        active    = (h_q >= H_ACT0) && (h_q <= H_ACT1) && (v_q >= V_ACT0) && (v_q <= V_ACT1);
        frame_end = (h_q == H_LAST) && (v_q == V_LAST);
        px        = h_q - H_ACT0;
        py        = v_q - V_ACT0;

        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
        end else begin
            h_d = h_q + 11'd1;
        end

        // Mode latch and colour step share the frame-end edge so the next frame sees both.
        if (frame_end) begin
            mode_d = mode_e'(Mode);
            if (frame_q == FRM_LAST) begin
                frame_d  = '0;
                colour_d = colour_q + 3'd1;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end

        if (active) begin
            if (sub_q == BAR_LAST) begin
                sub_d = '0;
                bar_d = bar_q + 3'd1;
            end else begin
                sub_d = sub_q + BW'(1);
            end
        end else begin
            sub_d = '0;
            bar_d = '0;
        end

        case (mode_q)
            MODE_BARS:  rgb = palette(bar_q);
            MODE_CHECK: rgb = (px[CHECK_LOG2] ^ py[CHECK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
`ifdef TFT_GRADIENT_PATTERN_EN
            MODE_GRAD:  rgb = {px[7:0], py[7:0], px[7:0] ^ py[7:0]};
            default:    rgb = palette(colour_q);
`else
            default:    rgb = palette(colour_q);
`endif
        endcase

        dena_d = active;
        hd_d   = (h_q < H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
        vd_d   = (v_q < V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
        fs_d   = (h_q == 11'd0) && (v_q == 11'd0);
        rgb_d  = active ? rgb : 24'h000000;
        pxo_d  = active ? px : 11'd0;
        pyo_d  = active ? py : 11'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(negedge CLK) begin
        if (Reset) begin
            h_q      <= '0;
            v_q      <= '0;
            frame_q  <= '0;
            colour_q <= '0;
            mode_q   <= MODE_SOLID;
            bar_q    <= '0;
            sub_q    <= '0;
            dena_q   <= 1'b0;
            hd_q     <= HSYNC_POL;
            vd_q     <= VSYNC_POL;
            fs_q     <= 1'b0;
            rgb_q    <= '0;
            pxo_q    <= '0;
            pyo_q    <= '0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            frame_q  <= frame_d;
            colour_q <= colour_d;
            mode_q   <= mode_d;
            bar_q    <= bar_d;
            sub_q    <= sub_d;
            dena_q   <= dena_d;
            hd_q     <= hd_d;
            vd_q     <= vd_d;
            fs_q     <= fs_d;
            rgb_q    <= rgb_d;
            pxo_q    <= pxo_d;
            pyo_q    <= pyo_d;
        end
    end

    assign DENA       = dena_q;
    assign HD         = hd_q;
    assign VD         = vd_q;
    assign SC         = 1'b0;
    assign Red        = rgb_q[23:16];
    assign Green      = rgb_q[15:8];
    assign Blue       = rgb_q[7:0];
    assign FrameStart = fs_q;
    assign PixelX     = pxo_q;
    assign PixelY     = pyo_q;

endmodule
